mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
MEM-stage memory access engine that consumes the ID-generated memory controls (read/write/sign-ext flags, byte select, store data) after they arrive through EX with the effective address. It issues a single-outstanding request on the SRAM-like data bus. It aligns store lanes and strobes, and extracts and extends load data. It holds the pipeline with `stall_req` until the access retires.

Parameters:
ADDR_W, 32, data bus address width
DATA_W, 32, data word width (fixed 32; byte lanes = DATA_W/8)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  MEM-stage instruction valid
mem_read_flag  in  1  load op
mem_write_flag  in  1  store op
mem_sign_ext_flag  in  1  sign-extend load result
mem_sel  in  4  unshifted size mask: 0001 byte, 0011 half, 1111 word
mem_write_data  in  32  store data, right-aligned
mem_addr  in  32  effective address from EX
alu_result  in  32  pass-through result for non-memory ops
out_data  out  32  result to WB
out_valid  out  1  out_data valid this cycle
stall_req  out  1  hold IF..MEM stages
addr_exc  out  1  misaligned access (see Optional Feature)
ram_req  out  1  bus request
ram_wr  out  1  1 = store
ram_size  out  2  0 byte, 1 half, 2 word
ram_wstrb  out  4  byte write strobes
ram_addr  out  32  word-aligned address, low 2 bits = mem_addr[1:0]
ram_wdata  out  32  lane-replicated store data
ram_addr_ok  in  1  request accepted
ram_rdata  in  32  read data
ram_data_ok  in  1  response (read data / write ack)

Behaviour:
- Reset: state=IDLE; ram_req=0, ram_wr=0, ram_wstrb=0, out_valid=0, stall_req=0, addr_exc=0; load data register=0.
- Memory op = in_valid & (mem_read_flag | mem_write_flag). Non-memory valid op: out_data=alu_result, out_valid=1 same cycle, stall_req=0.
- FSM:
  - IDLE: on memory op, go to REQ; stall_req=1 combinationally that cycle.
  - REQ: ram_req=1, with address/controls held stable; stay until ram_addr_ok. On ram_addr_ok go to WAIT.
  - WAIT: ram_req=0. On ram_data_ok, capture ram_rdata (loads), go to DONE.
  - DONE: stall_req=0, out_valid=1, out_data=extended load (store: 0). Next state IDLE.
- stall_req=1 in IDLE(mem op), REQ, WAIT; 0 in DONE.
- Minimum memory latency: addr_ok in first REQ cycle plus data_ok in next cycle gives 3 cycles from entry to out_valid.
- ram_data_ok is sampled only in WAIT. The bus never returns data_ok in the same cycle as addr_ok. data_ok seen in IDLE/REQ/DONE is discarded.
- Lanes, with off=mem_addr[1:0]: ram_wstrb = mem_sel << off (stores only, else 0). ram_wdata: byte replicated ×4, half replicated ×2, word as-is.
- Load extract: byte = rdata[8*off+:8], half = rdata[16*off[1]+:16]. Extend sign if mem_sign_ext_flag, else zero.
- rst in REQ/WAIT: abort to IDLE, ram_req drops next edge, and the late response is discarded.
- Upstream holds inputs stable while stall_req=1.

Optional Feature:
MEM_ALIGN_CHECK_EN.
- Defined: half with off[0]≠0 or word with off≠0 is misaligned. A misaligned op goes IDLE→DONE directly without asserting ram_req; addr_exc=1 in DONE, out_data=0.
- Undefined: no check; addr_exc tied 0; low address bits are used as given.

Decomposition:
- Shared package/header:
  - FSM state encodings (IDLE=0, REQ=1, WAIT=2, DONE=3).
  - ram_size codes.
  - MEM_SEL constants (byte/half/word).
  - DATA_BUS width macro.
- One sub-module `mem_load_ext` (combinational extract + sign/zero extend from rdata, off, sel, sign flag).

Test Plan:
- ALU op, in_valid=1, alu_result=0x1234 → out_data=0x1234, out_valid=1 same cycle, stall_req=0, ram_req=0.
- LB addr=0x...03, sign=1, rdata=0x80FF_0000 → out_data=0xFFFF_FF80; LBU same → 0x0000_0080.
- SB addr=0x...02, data=0x000000AB → ram_wstrb=0100, ram_wdata=0xABABABAB, ram_wr=1.
- LW with addr_ok delayed 3 cycles, data_ok 2 cycles later → ram_req high 4 cycles, stall_req high until DONE, out_data=rdata.
- rst asserted in WAIT, then data_ok arrives → state IDLE, out_valid stays 0, response ignored.
- With MEM_ALIGN_CHECK_EN: LH addr=0x...01 → no ram_req, addr_exc=1 one cycle, out_data=0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared FSM states, bus size codes and size-mask constants
`ifndef DATA_BUS
`define DATA_BUS 32
`endif
package mem_access_unit_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;
endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: pick the addressed byte/half out of a read word and sign/zero extend it
module mem_load_ext
  import mem_access_unit_pkg::*;
(
  input  logic [`DATA_BUS-1:0] rdata,
  input  logic [1:0]           off,
  input  logic [3:0]           sel,
  input  logic                 sign,
  output logic [`DATA_BUS-1:0] data
);
  logic [`DATA_BUS-1:0] b_sh, h_sh;
  assign b_sh = rdata >> {off, 3'b000};
  assign h_sh = rdata >> {off[1], 4'b0000};
  assign data = sel == SEL_WORD ? rdata :
                sel == SEL_HALF ? {{16{sign & h_sh[15]}}, h_sh[15:0]} :
                                  {{24{sign & b_sh[7]}}, b_sh[7:0]};
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage single-outstanding load/store bus engine (MEM_ALIGN_CHECK_EN enables misalignment traps)
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mem_read_flag,
  input  logic              mem_write_flag,
  input  logic              mem_sign_ext_flag,
  input  logic [3:0]        mem_sel,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              stall_req,
  output logic              addr_exc,
  output logic              ram_req,
  output logic              ram_wr,
  output logic [1:0]        ram_size,
  output logic [3:0]        ram_wstrb,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_addr_ok,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_data_ok
);
  state_t state, state_nx;
  logic [DATA_W-1:0] load_q, ext;
  logic [1:0] off;
  logic mem_op, is_word, is_half, misaligned;
  assign off     = mem_addr[1:0];
  assign mem_op  = in_valid & (mem_read_flag | mem_write_flag);
  assign is_word = mem_sel == SEL_WORD;
  assign is_half = mem_sel == SEL_HALF;
`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (is_half & off[0]) | (is_word & |off);
`else
  assign misaligned = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      load_q <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_WAIT && ram_data_ok && mem_read_flag) load_q <= ram_rdata;
    end
  end
  always_comb begin
    state_nx = state;
    state_nx = state == ST_IDLE ? (mem_op ? (misaligned ? ST_DONE : ST_REQ) : ST_IDLE) :
               state == ST_REQ  ? (ram_addr_ok ? ST_WAIT : ST_REQ) :
               state == ST_WAIT ? (ram_data_ok ? ST_DONE : ST_WAIT) : ST_IDLE;
  end
  mem_load_ext u_ext (
    .rdata (load_q),
    .off   (off),
    .sel   (mem_sel),
    .sign  (mem_sign_ext_flag),
    .data  (ext)
  );
  assign ram_req   = state == ST_REQ;
  assign ram_wr    = ram_req & mem_write_flag;
  assign ram_wstrb = ram_wr ? mem_sel << off : 4'b0000;
  assign ram_size  = is_word ? SIZE_WORD : is_half ? SIZE_HALF : SIZE_BYTE;
  assign ram_addr  = mem_addr;
  assign ram_wdata = is_word ? mem_write_data :
                     is_half ? {2{mem_write_data[15:0]}} : {4{mem_write_data[7:0]}};
  assign stall_req = (state == ST_IDLE & mem_op) | state == ST_REQ | state == ST_WAIT;
  assign out_valid = state == ST_DONE | (state == ST_IDLE & in_valid & ~mem_op);
  assign addr_exc  = state == ST_DONE & misaligned;
  assign out_data  = state == ST_DONE ? ((mem_write_flag | misaligned) ? '0 : ext) : alu_result;
endmodule
